// File: rtl/rv_multicycle_core_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_multicycle_core_if
// Description : Instruction-issue, load-data and store-data handshakes of the core.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_multicycle_core_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             inst_valid;
    logic             inst_ready;
    logic [31:0]      inst;
    logic [XLEN-1:0]  in_bus;
    logic             in_valid;
    logic [XLEN-1:0]  out_bus;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        output inst_valid, inst, in_bus, in_valid, out_ready,
        input  inst_ready, out_bus, out_valid, busy, illegal, instret
    );

    modport slave (
        input  inst_valid, inst, in_bus, in_valid, out_ready,
        output inst_ready, out_bus, out_valid, busy, illegal, instret
    );
endinterface
`default_nettype wire

// File: rtl/rv_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : rv_multicycle_core
// Description : Multi-cycle RV32I-subset core with register file, ALU and load/store handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_multicycle_core #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    rv_multicycle_core_if.slave bus
);
    localparam int RIW = $clog2(NREGS);
    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_DECODE = 2'b01;
    localparam logic [1:0] S_EXEC   = 2'b11;
    localparam logic [1:0] S_WB     = 2'b10;

    localparam logic [6:0] c_OP_LUI  = 7'b0110111;
    localparam logic [6:0] c_OP_IMM  = 7'b0010011;
    localparam logic [6:0] c_OP_REG  = 7'b0110011;
    localparam logic [6:0] c_OP_LOAD = 7'b0000011;
    localparam logic [6:0] c_OP_STOR = 7'b0100011;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [31:0]      r_inst;
    logic [XLEN-1:0]  r_regs [NREGS];
    logic [XLEN-1:0]  r_op_a;
    logic [XLEN-1:0]  r_op_b;
    logic [XLEN-1:0]  r_result;
    logic [XLEN-1:0]  r_out_bus;
    logic [CNT_W-1:0] r_instret;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic            w_rd_bad;
    logic            w_rs1_bad;
    logic            w_rs2_bad;
    logic            w_is_lui;
    logic            w_is_addi;
    logic            w_is_op;
    logic            w_is_lw;
    logic            w_is_sw;
    logic            w_legal;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_lui;
    logic [31:0]     w_u32;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu;

    assign w_opcode = r_inst[6:0];
    assign w_rd     = r_inst[11:7];
    assign w_f3     = r_inst[14:12];
    assign w_rs1    = r_inst[19:15];
    assign w_rs2    = r_inst[24:20];
    assign w_f7     = r_inst[31:25];

    // Index fields wider than the register file are flagged rather than aliased.
    generate
        if (RIW < 5) begin : g_idx_narrow
            assign w_rd_bad  = |w_rd[4:RIW];
            assign w_rs1_bad = |w_rs1[4:RIW];
            assign w_rs2_bad = |w_rs2[4:RIW];
        end else begin : g_idx_full
            assign w_rd_bad  = 1'b0;
            assign w_rs1_bad = 1'b0;
            assign w_rs2_bad = 1'b0;
        end
    endgenerate

    assign w_is_lui  = (w_opcode == c_OP_LUI);
    assign w_is_addi = (w_opcode == c_OP_IMM) && (w_f3 == 3'b000);
    assign w_is_op   = (w_opcode == c_OP_REG) &&
                       (((w_f7 == 7'b0000000) && ((w_f3 == 3'b000) || (w_f3 == 3'b001) ||
                                                  (w_f3 == 3'b101) || (w_f3 == 3'b111))) ||
                        ((w_f7 == 7'b0100000) && (w_f3 == 3'b000)));
    assign w_is_lw   = (w_opcode == c_OP_LOAD) && (w_f3 == 3'b010);
    assign w_is_sw   = (w_opcode == c_OP_STOR) && (w_f3 == 3'b010);

    assign w_legal = (w_is_lui  && !w_rd_bad) ||
                     (w_is_addi && !(w_rd_bad || w_rs1_bad)) ||
                     (w_is_op   && !(w_rd_bad || w_rs1_bad || w_rs2_bad)) ||
                     (w_is_lw   && !(w_rd_bad || w_rs1_bad)) ||
                     (w_is_sw   && !(w_rs1_bad || w_rs2_bad));

    // x0 is never written, so its reset value of zero is permanent.
    assign w_rs1_val = r_regs[w_rs1[RIW-1:0]];
    assign w_rs2_val = r_regs[w_rs2[RIW-1:0]];

    assign w_imm_i = {{(XLEN-12){r_inst[31]}}, r_inst[31:20]};
    assign w_u32   = {r_inst[31:12], 12'd0};

    generate
        if (XLEN > 32) begin : g_lui_wide
            assign w_lui = {{(XLEN-32){w_u32[31]}}, w_u32};
        end else begin : g_lui_narrow
            assign w_lui = w_u32[XLEN-1:0];
        end
    endgenerate

    assign w_shamt = r_op_b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        if (w_is_lui) begin
            w_alu = w_lui;
        end else if (w_is_addi) begin
            w_alu = r_op_a + w_imm_i;
        end else if (w_is_op) begin
            case (w_f3)
                3'b000:  w_alu = w_f7[5] ? (r_op_a - r_op_b) : (r_op_a + r_op_b);
                3'b001:  w_alu = r_op_a << w_shamt;
                3'b101:  w_alu = r_op_a >> w_shamt;
                3'b111:  w_alu = r_op_a & r_op_b;
                default: w_alu = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.inst_valid) w_next = S_DECODE;
            S_DECODE: w_next = w_legal ? S_EXEC : S_IDLE;
            S_EXEC: begin
                if (w_is_lw) begin
                    if (bus.in_valid) w_next = S_WB;
                end else if (w_is_sw) begin
                    if (bus.out_ready) w_next = S_WB;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB:     w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.inst_ready = (r_state == S_IDLE);
        bus.busy       = (r_state != S_IDLE);
        bus.out_valid  = (r_state == S_EXEC) && w_is_sw;
        bus.illegal    = (r_state == S_DECODE) && !w_legal;
        bus.out_bus    = r_out_bus;
        bus.instret    = r_instret;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst    <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_result  <= '0;
            r_out_bus <= '0;
            r_instret <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.inst_valid) r_inst <= bus.inst;
                end
                S_DECODE: begin
                    r_op_a <= w_rs1_val;
                    r_op_b <= w_rs2_val;
                    if (w_is_sw && w_legal) r_out_bus <= w_rs2_val;
                end
                S_EXEC: begin
                    if (w_is_lw) begin
                        if (bus.in_valid) r_result <= bus.in_bus;
                    end else begin
                        r_result <= w_alu;
                    end
                end
                S_WB: begin
                    if (!w_is_sw && (w_rd != 5'd0)) r_regs[w_rd[RIW-1:0]] <= r_result;
                    r_instret <= r_instret + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rv_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_multicycle_core
// Description : Directed self-checking bench for rv_multicycle_core (XLEN=32 and XLEN=16 builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_multicycle_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rv_multicycle_core_if #(.XLEN(32), .CNT_W(32)) bus ();
    rv_multicycle_core_if #(.XLEN(16), .CNT_W(32)) bus16 ();

    rv_multicycle_core #(.XLEN(32), .NREGS(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    rv_multicycle_core #(.XLEN(16), .NREGS(16), .CNT_W(32)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_lui(input int rd, input logic [19:0] imm);
        return {imm, 5'(rd), 7'b0110111};
    endfunction
    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input logic [11:0] imm);
        return {imm, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input int rd, input int rs1, input int rs2);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_lw(input int rd);
        return {12'd0, 5'd0, 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_sw(input int rs2);
        return {7'd0, 5'(rs2), 5'd0, 3'b010, 5'd0, 7'b0100011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] ins);
        bus.inst       = ins;
        bus.inst_valid = 1'b1;
        tick();
        bus.inst_valid = 1'b0;
        bus.inst       = 32'hFFFF_FFFF;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 64) begin
            n++;
            tick();
        end
        chk("idle_reached", {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic run(input logic [31:0] ins);
        int n;
        accept(ins);
        wait_idle(n);
    endtask

    task automatic read_reg(input int r, output logic [31:0] v);
        run(enc_sw(r));
        v = bus.out_bus;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int          n;
        logic [31:0] v;

        bus.inst_valid = 1'b0;  bus.inst = '0;  bus.in_bus = '0;
        bus.in_valid   = 1'b0;  bus.out_ready = 1'b1;
        bus16.inst_valid = 1'b0; bus16.inst = '0; bus16.in_bus = '0;
        bus16.in_valid   = 1'b0; bus16.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_inst_ready", {63'd0, bus.inst_ready}, 64'd1);
        chk("rst_busy",       {63'd0, bus.busy},       64'd0);
        chk("rst_out_valid",  {63'd0, bus.out_valid},  64'd0);
        chk("rst_out_bus",    {32'd0, bus.out_bus},    64'd0);
        chk("rst_illegal",    {63'd0, bus.illegal},    64'd0);
        chk("rst_instret",    {32'd0, bus.instret},    64'd0);
        rst_n = 1'b1;
        tick();

        // LUI latency and result
        accept(enc_lui(5, 20'h12345));
        chk("lui_ready_low", {63'd0, bus.inst_ready}, 64'd0);
        wait_idle(n);
        chk("lui_busy_cycles", 64'(n), 64'd3);
        chk("lui_instret", {32'd0, bus.instret}, 64'd1);
        read_reg(5, v);
        chk("lui_x5", {32'd0, v}, 64'h1234_5000);

        // ADD / SUB with negative operand
        do_reset();
        run(enc_addi(1, 0, 12'hFFF));
        run(enc_addi(2, 0, 12'h001));
        run(enc_r(7'b0000000, 3'b000, 3, 1, 2));
        run(enc_r(7'b0100000, 3'b000, 4, 2, 1));
        chk("arith_instret", {32'd0, bus.instret}, 64'd4);
        read_reg(3, v);
        chk("add_x3", {32'd0, v}, 64'h0);
        read_reg(4, v);
        chk("sub_x4", {32'd0, v}, 64'h2);

        // Shifts use only the low five bits of rs2
        run(enc_lui(1, 20'h80000));
        run(enc_addi(1, 1, 12'h001));
        run(enc_addi(2, 0, 12'd33));
        run(enc_r(7'b0000000, 3'b001, 3, 1, 2));
        run(enc_r(7'b0000000, 3'b101, 4, 1, 2));
        run(enc_r(7'b0000000, 3'b111, 6, 1, 2));
        read_reg(3, v);
        chk("sll_x3", {32'd0, v}, 64'h0000_0002);
        read_reg(4, v);
        chk("srl_x4", {32'd0, v}, 64'h4000_0000);
        read_reg(6, v);
        chk("and_x6", {32'd0, v}, 64'h0000_0001);

        // Load with in_valid held off for four EXEC cycles
        bus.in_bus   = 32'hDEAD_BEEF;
        bus.in_valid = 1'b0;
        accept(enc_lw(7));
        n = 0;
        while (bus.busy && n < 64) begin
            n++;
            if (n == 6) bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("lw_busy_cycles", 64'(n), 64'd7);
        read_reg(7, v);
        chk("lw_x7", {32'd0, v}, 64'hDEAD_BEEF);
        run(enc_addi(0, 0, 12'd5));
        read_reg(0, v);
        chk("x0_zero", {32'd0, v}, 64'h0);

        // Store with backpressure
        run(enc_lui(8, 20'hA5A5A));
        run(enc_addi(8, 8, 12'h5A5));
        bus.out_ready = 1'b0;
        accept(enc_sw(8));
        chk("sw_decode_no_valid", {63'd0, bus.out_valid}, 64'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("sw_hold_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("sw_hold_data", {32'd0, bus.out_bus}, 64'hA5A5_A5A5);
            tick();
        end
        bus.out_ready = 1'b1;
        chk("sw_valid_at_ready", {63'd0, bus.out_valid}, 64'd1);
        tick();
        chk("sw_valid_dropped", {63'd0, bus.out_valid}, 64'd0);
        wait_idle(n);

        // Reset while a store is stalled
        bus.out_ready = 1'b0;
        accept(enc_sw(8));
        tick();
        chk("sw2_valid", {63'd0, bus.out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("abort_instret", {32'd0, bus.instret}, 64'd0);
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();

        // Unsupported opcode
        run(enc_addi(9, 0, 12'd7));
        accept({20'd0, 5'd9, 7'b1111111});
        chk("illegal_pulse", {63'd0, bus.illegal}, 64'd1);
        tick();
        chk("illegal_cleared", {63'd0, bus.illegal}, 64'd0);
        chk("illegal_idle", {63'd0, bus.busy}, 64'd0);
        chk("illegal_instret", {32'd0, bus.instret}, 64'd1);
        read_reg(9, v);
        chk("illegal_x9_kept", {32'd0, v}, 64'd7);

        // 16-bit build with 16 registers: rd=17 is out of range
        bus16.inst       = {12'd1, 5'd0, 3'b000, 5'd17, 7'b0010011};
        bus16.inst_valid = 1'b1;
        tick();
        bus16.inst_valid = 1'b0;
        chk("x16_illegal_rd", {63'd0, bus16.illegal}, 64'd1);
        tick();
        chk("x16_illegal_clear", {63'd0, bus16.illegal}, 64'd0);
        chk("x16_instret0", {32'd0, bus16.instret}, 64'd0);
        bus16.inst       = enc_addi(3, 0, 12'hFFF);
        bus16.inst_valid = 1'b1;
        tick();
        bus16.inst_valid = 1'b0;
        tick(); tick(); tick();
        bus16.inst       = enc_sw(3);
        bus16.inst_valid = 1'b1;
        tick();
        bus16.inst_valid = 1'b0;
        tick(); tick(); tick();
        chk("x16_sw_data", {48'd0, bus16.out_bus}, 64'hFFFF);
        chk("x16_instret2", {32'd0, bus16.instret}, 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
